// File: rtl/pulse_train_gen_pkg.sv
// Shared types and default widths for the pulse-count link (transmit and receive side).
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } pg_state_t;

    localparam int CNT_W_DEF   = 5;
    localparam int WIDTH_W_DEF = 8;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request/status bundle of the pulse train generator.
// The master issues burst requests; the slave (the generator) reports progress.
interface pulse_train_gen_if #(
    parameter int CNT_W   = pulse_gen_pkg::CNT_W_DEF,
    parameter int WIDTH_W = pulse_gen_pkg::WIDTH_W_DEF
);
    logic               start;
    logic               abort;
    logic [CNT_W-1:0]   num_pulses;
    logic [WIDTH_W-1:0] high_len;
    logic [WIDTH_W-1:0] low_len;
    logic               sig_out;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   sent_count;

    modport master (
        output start, abort, num_pulses, high_len, low_len,
        input  sig_out, busy, done, sent_count
    );

    modport slave (
        input  start, abort, num_pulses, high_len, low_len,
        output sig_out, busy, done, sent_count
    );
endinterface

// File: rtl/pulse_train_gen_phase_timer.sv
// Phase length timer: loaded with len-1 on phase entry, counts down to zero.
// expired marks the last cycle of the phase; a length of 0 is stretched to 1.
module phase_timer #(
    parameter int WIDTH_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH_W-1:0] len,
    output logic               expired
);
    localparam logic [WIDTH_W-1:0] ONE = WIDTH_W'(1);

    logic [WIDTH_W-1:0] cnt_q;
    logic [WIDTH_W-1:0] cnt_d;

    // Next count: reload on phase entry, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (len == '0) ? '0 : (len - ONE);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);
endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: on start emits num_pulses high/low pulses on sig_out,
// then flags done for one cycle. All outputs come straight from flops.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int WIDTH_W = WIDTH_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    pulse_train_gen_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pg_state_t          state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [WIDTH_W-1:0] high_q, high_d;
    logic [WIDTH_W-1:0] low_q, low_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic               sig_q, sig_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               tmr_load;
    logic [WIDTH_W-1:0] tmr_len;
    logic               tmr_expired;

    phase_timer #(.WIDTH_W(WIDTH_W)) u_phase_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .len     (tmr_len),
        .expired (tmr_expired)
    );

    // Next-state and next-output logic. Outputs are computed one cycle ahead so that
    // sig_out/busy/done change together with the state they belong to.
    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        high_d   = high_q;
        low_d    = low_q;
        sent_d   = sent_q;
        sig_d    = sig_q;
        busy_d   = busy_q;
        done_d   = done_q;
        tmr_load = 1'b0;
        tmr_len  = high_q;

        case (state_q)
            IDLE: begin
                sig_d  = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b0;
                if (bus.start && !bus.abort) begin
                    num_d  = bus.num_pulses;
                    high_d = bus.high_len;
                    low_d  = bus.low_len;
                    busy_d = 1'b1;
                    if (bus.num_pulses == '0) begin
                        state_d = DONE;
                        sent_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        // First high phase timed from the live input; the latch lands this edge.
                        state_d  = HIGH;
                        sent_d   = CNT_ONE;
                        sig_d    = 1'b1;
                        tmr_load = 1'b1;
                        tmr_len  = bus.high_len;
                    end
                end
            end
            HIGH: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    sig_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (tmr_expired) begin
                    state_d  = LOW;
                    sig_d    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_len  = low_q;
                end
            end
            LOW: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    sig_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else if (tmr_expired) begin
                    if (sent_q < num_q) begin
                        state_d  = HIGH;
                        sig_d    = 1'b1;
                        sent_d   = sent_q + CNT_ONE;
                        tmr_load = 1'b1;
                        tmr_len  = high_q;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                sig_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                sig_d   = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State, latched configuration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            sent_q  <= '0;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            high_q  <= high_d;
            low_q   <= low_d;
            sent_q  <= sent_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sig_out    = sig_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sent_count = sent_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen. Waveforms are captured one bit per cycle,
// bit c-1 holding cycle c after the start-sampling edge.
module tb_pulse_train_gen;
    import pulse_gen_pkg::*;

    localparam int CW = 5;
    localparam int WW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pulse_train_gen_if #(.CNT_W(CW), .WIDTH_W(WW)) bus ();

    pulse_train_gen #(.CNT_W(CW), .WIDTH_W(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] w_sig;
    logic [63:0] w_busy;
    logic [63:0] w_done;
    int          edges;
    int          max_fires;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records ncyc cycles. abort is raised in cycle abort_cyc; stray start requests with
    // a different config are raised in cycles junk_from..junk_to. Edges feed a model of
    // the receive-side counter (MAX_COUNT=10) whose max_reached fires on the 10th edge.
    task automatic capture(input int ncyc, input int abort_cyc, input int junk_from, input int junk_to);
        logic prev;
        prev      = 1'b0;
        w_sig     = '0;
        w_busy    = '0;
        w_done    = '0;
        edges     = 0;
        max_fires = 0;
        for (int c = 1; c <= ncyc; c++) begin
            w_sig[c-1]  = bus.sig_out;
            w_busy[c-1] = bus.busy;
            w_done[c-1] = bus.done;
            if (bus.sig_out && !prev) begin
                edges++;
                if (edges == 10) max_fires++;
            end
            prev      = bus.sig_out;
            bus.abort = (c == abort_cyc);
            if (c >= junk_from && c <= junk_to) begin
                bus.start      = 1'b1;
                bus.num_pulses = 5'd1;
                bus.high_len   = 8'd9;
                bus.low_len    = 8'd9;
            end else begin
                bus.start = 1'b0;
            end
            step();
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic launch(input int n, input int h, input int l);
        bus.num_pulses = CW'(n);
        bus.high_len   = WW'(h);
        bus.low_len    = WW'(l);
        bus.start      = 1'b1;
        step();
        bus.start      = 1'b0;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.num_pulses = '0;
        bus.high_len   = '0;
        bus.low_len    = '0;

        // Reset and idle
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        capture(20, 0, 0, 0);
        chk("idle_sig",  w_sig,  64'h0);
        chk("idle_busy", w_busy, 64'h0);
        chk("idle_done", w_done, 64'h0);
        chk("idle_sent", 64'(bus.sent_count), 64'd0);

        // N=3 H=2 L=3: high 1-2, 6-7, 11-12; done 16
        launch(3, 2, 3);
        capture(18, 0, 0, 0);
        chk("b3_sig",   w_sig,  64'hC63);
        chk("b3_done",  w_done, 64'h8000);
        chk("b3_busy",  w_busy, 64'hFFFF);
        chk("b3_edges", 64'(edges), 64'd3);
        chk("b3_sent",  64'(bus.sent_count), 64'd3);

        // N=0: done and busy in cycle 1 only; start in the done cycle is ignored
        launch(0, 4, 4);
        capture(1, 0, 1, 1);
        chk("n0_sig",  w_sig,  64'h0);
        chk("n0_done", w_done, 64'h1);
        chk("n0_busy", w_busy, 64'h1);
        chk("n0_busy_after", 64'(bus.busy), 64'd0);
        chk("n0_sent", 64'(bus.sent_count), 64'd0);

        // N=4 H=0 L=0, started the cycle after done: period 2, done cycle 9
        launch(4, 0, 0);
        capture(11, 0, 0, 0);
        chk("z_sig",   w_sig,  64'h55);
        chk("z_done",  w_done, 64'h100);
        chk("z_busy",  w_busy, 64'h1FF);
        chk("z_edges", 64'(edges), 64'd4);
        chk("z_sent",  64'(bus.sent_count), 64'd4);

        // N=5 H=1 L=1, abort in cycle 4, stray starts in cycles 2-3
        launch(5, 1, 1);
        capture(8, 4, 2, 3);
        chk("ab_sig",  w_sig,  64'h5);
        chk("ab_busy", w_busy, 64'hF);
        chk("ab_done", w_done, 64'h0);
        chk("ab_sent", 64'(bus.sent_count), 64'd2);

        // start together with abort in IDLE: stays idle, counters untouched
        bus.num_pulses = 5'd3;
        bus.high_len   = 8'd1;
        bus.low_len    = 8'd1;
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        step();
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        capture(3, 0, 0, 0);
        chk("sa_busy", w_busy, 64'h0);
        chk("sa_sig",  w_sig,  64'h0);
        chk("sa_sent", 64'(bus.sent_count), 64'd2);

        // Loopback to counter model: N=11 H=1 L=2, done cycle 34
        launch(11, 1, 2);
        capture(36, 0, 0, 0);
        chk("lb_sig",   w_sig,  64'h49249249);
        chk("lb_done",  w_done, 64'h2_0000_0000);
        chk("lb_busy",  w_busy, 64'h3_FFFF_FFFF);
        chk("lb_edges", 64'(edges), 64'd11);
        chk("lb_maxreached", 64'(max_fires), 64'd1);
        chk("lb_sent",  64'(bus.sent_count), 64'd11);

        // Reset mid-burst (with start also high): outputs 0 next cycle
        launch(5, 3, 3);
        step();
        step();
        step();
        chk("mr_pre_sent", 64'(bus.sent_count), 64'd1);
        chk("mr_pre_busy", 64'(bus.busy), 64'd1);
        rst       = 1'b1;
        bus.start = 1'b1;
        step();
        chk("mr_sig",  64'(bus.sig_out), 64'd0);
        chk("mr_busy", 64'(bus.busy), 64'd0);
        chk("mr_done", 64'(bus.done), 64'd0);
        chk("mr_sent", 64'(bus.sent_count), 64'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        chk("mr_after_busy", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
